// File: rtl/led_row_scan_driver.sv
// led_row_scan_driver
//   Time-multiplexes eight 8-bit row images onto an 8x8 LED matrix, one row
//   at a time. A shadow copy of all rows is taken once per frame so that
//   input changes mid-scan never tear the picture. Every row is preceded by
//   a blanking gap, and a one-cycle frame_done pulse marks each completed
//   frame.
//
// Ports
//   clk            system clock
//   rst_n          asynchronous, active-low reset
//   enable         scan enable; sampled in IDLE and at the end of each dwell
//   row_1..row_8   merged row images, bit i = column i
//   row_sel        one-hot row strobe (bit 0 = row_1), 8'h00 = no row active
//   col_out        column data of the selected row (inverted if COL_ACTIVE_LOW)
//   frame_done     one-cycle pulse after row_8 finishes its dwell
module led_row_scan_driver #(
  parameter int unsigned DWELL          = 16,   // 1..65535
  parameter int unsigned BLANK          = 2,    // 1..255
  parameter logic        COL_ACTIVE_LOW = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic [7:0] row_1,
  input  logic [7:0] row_2,
  input  logic [7:0] row_3,
  input  logic [7:0] row_4,
  input  logic [7:0] row_5,
  input  logic [7:0] row_6,
  input  logic [7:0] row_7,
  input  logic [7:0] row_8,
  output logic [7:0] row_sel,
  output logic [7:0] col_out,
  output logic       frame_done
);

  // Inactive column level doubles as the inversion mask.
  localparam logic [7:0]  COL_IDLE   = COL_ACTIVE_LOW ? 8'hFF : 8'h00;
  localparam logic [15:0] DWELL_LAST = 16'(DWELL - 1);
  localparam logic [7:0]  BLANK_LAST = 8'(BLANK - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BLANK,
    S_DRIVE
  } state_e;

  state_e          state_q, state_d;
  logic [2:0]      row_idx_q, row_idx_d;
  logic [15:0]     dwell_cnt_q, dwell_cnt_d;
  logic [7:0]      blank_cnt_q, blank_cnt_d;
  logic [7:0][7:0] shadow_q, shadow_d;
  logic [7:0][7:0] rows_in;
  logic [7:0]      row_sel_q, row_sel_d;
  logic [7:0]      col_out_q, col_out_d;
  logic            frame_done_q, frame_done_d;

  // Element 0 is row_1.
  assign rows_in = {row_8, row_7, row_6, row_5, row_4, row_3, row_2, row_1};

  always_comb begin
    state_d      = state_q;
    row_idx_d    = row_idx_q;
    dwell_cnt_d  = dwell_cnt_q;
    blank_cnt_d  = blank_cnt_q;
    shadow_d     = shadow_q;
    frame_done_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (enable) begin
          shadow_d    = rows_in;
          row_idx_d   = '0;
          dwell_cnt_d = '0;
          blank_cnt_d = '0;
          state_d     = S_BLANK;
        end
      end
      S_BLANK: begin
        if (blank_cnt_q == BLANK_LAST) begin
          blank_cnt_d = '0;
          dwell_cnt_d = '0;
          state_d     = S_DRIVE;
        end else begin
          blank_cnt_d = blank_cnt_q + 8'd1;
        end
      end
      S_DRIVE: begin
        if (dwell_cnt_q == DWELL_LAST) begin
          dwell_cnt_d = '0;
          if (row_idx_q == 3'd7) begin
            // Frame completed: pulse regardless of enable, recapture on the
            // same edge so the next frame starts from a fresh snapshot.
            frame_done_d = 1'b1;
            if (enable) begin
              shadow_d  = rows_in;
              row_idx_d = '0;
              state_d   = S_BLANK;
            end else begin
              state_d   = S_IDLE;
            end
          end else if (enable) begin
            row_idx_d = row_idx_q + 3'd1;
            state_d   = S_BLANK;
          end else begin
            state_d   = S_IDLE;
          end
        end else begin
          dwell_cnt_d = dwell_cnt_q + 16'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are decoded from the next state so the registered copies line
    // up exactly with the state they describe.
    row_sel_d = '0;
    col_out_d = COL_IDLE;
    if (state_d == S_DRIVE) begin
      row_sel_d = 8'h01 << row_idx_d;
      col_out_d = shadow_d[row_idx_d] ^ COL_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      row_idx_q    <= '0;
      dwell_cnt_q  <= '0;
      blank_cnt_q  <= '0;
      shadow_q     <= '0;
      row_sel_q    <= '0;
      col_out_q    <= COL_IDLE;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      row_idx_q    <= row_idx_d;
      dwell_cnt_q  <= dwell_cnt_d;
      blank_cnt_q  <= blank_cnt_d;
      shadow_q     <= shadow_d;
      row_sel_q    <= row_sel_d;
      col_out_q    <= col_out_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign row_sel    = row_sel_q;
  assign col_out    = col_out_q;
  assign frame_done = frame_done_q;

endmodule
